// File: rtl/psg_reg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// psg_pkg
// Shared constants for the PSG configuration front end: the 3-bit register
// pointer encoding used by latch bytes, the reset attenuation value and the
// noise control width.
// ---------------------------------------------------------------------------
package psg_pkg;

  // Register pointer: bits [2:1] select the channel, bit [0] selects volume.
  localparam logic [2:0] REG_TONE0 = 3'd0;
  localparam logic [2:0] REG_ATT0  = 3'd1;
  localparam logic [2:0] REG_TONE1 = 3'd2;
  localparam logic [2:0] REG_ATT1  = 3'd3;
  localparam logic [2:0] REG_TONE2 = 3'd4;
  localparam logic [2:0] REG_ATT2  = 3'd5;
  localparam logic [2:0] REG_NOISE = 3'd6;
  localparam logic [2:0] REG_ATT3  = 3'd7;

  localparam logic [3:0] ATTEN_SILENT    = 4'hF;
  localparam int         NOISE_CTRL_BITS = 3;

endpackage

// File: rtl/psg_reg_ctrl_if.sv
// ---------------------------------------------------------------------------
// psg_reg_ctrl_if
// CPU write port of the PSG.
//   data  : write byte (CPU -> PSG)
//   wr    : write strobe (CPU -> PSG)
//   ready : 1 = next write will be accepted (PSG -> CPU)
// ---------------------------------------------------------------------------
interface psg_reg_ctrl_if;
  logic [7:0] data;
  logic       wr;
  logic       ready;

  modport master (output data, output wr, input ready);
  modport slave  (input data, input wr, output ready);
endinterface

// File: rtl/psg_reg_ctrl_busy_timer.sv
// ---------------------------------------------------------------------------
// psg_busy_timer
// Holds ready low for exactly BUSY_CYCLES cycles after an accepted write.
// Down-counter loaded on start; ready is the terminal-count compare (== 0).
//   clk, reset : clock, synchronous active-high reset
//   start      : accepted write this cycle (only asserted while ready=1)
//   ready      : 1 when the counter has expired
// ---------------------------------------------------------------------------
module psg_busy_timer #(
  parameter int BUSY_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready
);

  localparam int         CW   = $clog2(BUSY_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(BUSY_CYCLES);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= LOAD;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign ready = (count_q == '0);

endmodule

// File: rtl/psg_reg_ctrl.sv
// ---------------------------------------------------------------------------
// psg_reg_ctrl
// Configuration front end of the SN76489-compatible PSG. Decodes CPU latch /
// data bytes into the eight PSG registers and drives the tone compares, noise
// control and attenuators.
//
// Build option: define PSG_WRITE_BUSY_EN to hold ready low for BUSY_CYCLES
// cycles after every accepted write; otherwise ready is tied high.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   bus (slave)         data/wr in, ready out
//   tone0..2_compare    tone periods
//   noise_ctrl          [2]=white/periodic, [1:0]=shift rate
//   noise_restart       one-cycle pulse on every accepted noise write
//   atten0..3           attenuation (0..2 tone, 3 noise), F = silent
// ---------------------------------------------------------------------------
module psg_reg_ctrl #(
  parameter int COUNTER_BITS = 10,
  parameter int VALUE_BITS   = 4,
  parameter int BUSY_CYCLES  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  psg_reg_ctrl_if.slave            bus,
  output logic [COUNTER_BITS-1:0]  tone0_compare,
  output logic [COUNTER_BITS-1:0]  tone1_compare,
  output logic [COUNTER_BITS-1:0]  tone2_compare,
  output logic [2:0]               noise_ctrl,
  output logic                     noise_restart,
  output logic [VALUE_BITS-1:0]    atten0,
  output logic [VALUE_BITS-1:0]    atten1,
  output logic [VALUE_BITS-1:0]    atten2,
  output logic [VALUE_BITS-1:0]    atten3
);

  import psg_pkg::*;

  // The byte protocol carries exactly 4 + 6 period bits and 4 volume bits.
  if (COUNTER_BITS != 10) $error("psg_reg_ctrl: COUNTER_BITS must be 10");
  if (VALUE_BITS != 4)    $error("psg_reg_ctrl: VALUE_BITS must be 4");
  if (BUSY_CYCLES < 1)    $error("psg_reg_ctrl: BUSY_CYCLES must be >= 1");

  logic                    ready;
  logic                    accept;
  logic [2:0]              ptr_q;
  logic [2:0]              target;
  logic [COUNTER_BITS-1:0] tone_q [3];
  logic [VALUE_BITS-1:0]   atten_q [4];
  logic [NOISE_CTRL_BITS-1:0] noise_q;

`ifdef PSG_WRITE_BUSY_EN
  psg_busy_timer #(
    .BUSY_CYCLES (BUSY_CYCLES)
  ) u_busy_timer (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .ready (ready)
  );
`else
  assign ready = 1'b1;
`endif

  assign bus.ready = ready;
  assign accept    = bus.wr & ready;

  // A latch byte addresses its own register in the same cycle.
  assign target = bus.data[7] ? bus.data[6:4] : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= REG_TONE0;
      noise_q       <= '0;
      noise_restart <= 1'b0;
      for (int i = 0; i < 3; i++) tone_q[i]  <= '0;
      for (int i = 0; i < 4; i++) atten_q[i] <= ATTEN_SILENT;
    end else begin
      noise_restart <= 1'b0;
      if (accept) begin
        if (bus.data[7]) ptr_q <= bus.data[6:4];
        if (target == REG_NOISE) begin
          noise_q       <= bus.data[2:0];
          noise_restart <= 1'b1;
        end else if (target[0]) begin
          // odd pointers are volumes; REG_ATT3 lands on index 3
          atten_q[target[2:1]] <= bus.data[3:0];
        end else if (bus.data[7]) begin
          tone_q[target[2:1]][3:0] <= bus.data[3:0];
        end else begin
          tone_q[target[2:1]][9:4] <= bus.data[5:0];
        end
      end
    end
  end

  assign tone0_compare = tone_q[0];
  assign tone1_compare = tone_q[1];
  assign tone2_compare = tone_q[2];
  assign noise_ctrl    = noise_q;
  assign atten0        = atten_q[0];
  assign atten1        = atten_q[1];
  assign atten2        = atten_q[2];
  assign atten3        = atten_q[3];

endmodule
